xdma_read_data_path: RTL and testbench



---
 rtl/xdma_pkg.sv | 22 ++
 rtl/xdma_r_skid.sv | 63 ++++++
 rtl/xdma_read_data_path.sv | 124 ++++++++++++
 tb/tb_xdma_read_data_path.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_pkg.sv
// Shared types for the xDMA read data path: descriptor, completion status and FSM state.
package xdma_pkg;

  typedef struct packed {
    logic [7:0] num_beats;     // AXI len: beats minus one
    logic       is_read_data;  // 1 = forward to local stream, 0 = discard
  } xdma_req_r_desc_t;

  typedef struct packed {
    logic resp_err;
    logic last_missing;
    logic last_early;
  } xdma_r_status_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } xdma_r_state_e;

endpackage

// File: rtl/xdma_r_skid.sv
// Two-entry registered FIFO between the AXI R channel and the local read-response stream.
module xdma_r_skid #(
  parameter type data_t = logic [31:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  data_t push_data_i,
  input  logic  push_valid_i,
  output logic  push_ready_o,
  output data_t pop_data_o,
  output logic  pop_valid_o,
  input  logic  pop_ready_i,
  output logic  empty_o
);

  data_t      mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  // Both sides depend only on the occupancy register, so ready never follows pop_ready_i.
  assign push_ready_o = (cnt_q != 2'd2);
  assign pop_valid_o  = (cnt_q != 2'd0);
  assign empty_o      = (cnt_q == 2'd0);
  assign pop_data_o   = mem_q[rd_ptr_q];

  assign push = push_valid_i && push_ready_o;
  assign pop  = pop_valid_o && pop_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xdma_read_data_path.sv
// Receives the AXI R beats of one read descriptor, forwards or drops them, checks RLAST/RRESP
// and returns the descriptor with a one-cycle done/status pulse.
module xdma_read_data_path
  import xdma_pkg::*;
#(
  parameter type data_t = logic [31:0]
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  xdma_req_r_desc_t r_desc_i,
  input  logic             r_dp_valid_i,
  output logic             r_dp_ready_o,
  output logic [2:0]       status_o,
  input  data_t            r_data_i,
  input  logic [1:0]       r_resp_i,
  input  logic             r_last_i,
  input  logic             r_valid_i,
  output logic             r_ready_o,
  output data_t            read_rsp_data_o,
  output logic             read_rsp_data_valid_o,
  input  logic             read_rsp_data_ready_i,
  output xdma_r_state_e    dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a valid source keeps
  // its payload stable until that edge. The descriptor handshake completes on r_dp_ready_o.

  xdma_r_state_e  state_q, state_d;
  logic           fwd_q, fwd_d;
  logic [7:0]     cnt_q, cnt_d;
  xdma_r_status_t flags_q, flags_d;

  logic beat_acc, push_valid, push_ready, skid_empty, skid_flush;
  logic unused_resp;

  assign unused_resp = r_resp_i[0];  // only the error bit of RRESP matters here
  assign dbg_state_o = state_q;

  assign beat_acc   = r_valid_i && r_ready_o;
  assign push_valid = beat_acc && fwd_q;
  assign skid_flush = (state_q == IDLE) && r_dp_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_q   <= 1'b0;
      cnt_q   <= 8'd0;
      flags_q <= '0;
    end else begin
      fwd_q   <= fwd_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fwd_d   = fwd_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (r_dp_valid_i) begin
          fwd_d   = r_desc_i.is_read_data;
          cnt_d   = r_desc_i.num_beats;
          flags_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (beat_acc) begin
          if (r_resp_i[1]) flags_d.resp_err = 1'b1;
          // A zero count marks the expected last beat, so the counter never wraps.
          if (cnt_q == 8'd0) begin
            if (!r_last_i) flags_d.last_missing = 1'b1;
            state_d = DRAIN;
          end else if (r_last_i) begin
            flags_d.last_early = 1'b1;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      DRAIN:   if (skid_empty) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_ready_o    = 1'b0;
    r_dp_ready_o = 1'b0;
    status_o     = 3'b000;
    case (state_q)
      BUSY:    r_ready_o = fwd_q ? push_ready : 1'b1;
      FINISH: begin
        r_dp_ready_o = 1'b1;
        status_o     = flags_q;
      end
      default: ;
    endcase
  end

  xdma_r_skid #(
    .data_t (data_t)
  ) u_skid (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (skid_flush),
    .push_data_i  (r_data_i),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .pop_data_o   (read_rsp_data_o),
    .pop_valid_o  (read_rsp_data_valid_o),
    .pop_ready_i  (read_rsp_data_ready_i),
    .empty_o      (skid_empty)
  );

endmodule

// File: tb/tb_xdma_read_data_path.sv
// Directed and randomized descriptors for xdma_read_data_path, checked against a beat-level model.
module tb_xdma_read_data_path;
  import xdma_pkg::*;

  typedef logic [31:0] data_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  xdma_req_r_desc_t r_desc_i;
  logic             r_dp_valid_i;
  logic             r_dp_ready_o;
  logic [2:0]       status_o;
  data_t            r_data_i;
  logic [1:0]       r_resp_i;
  logic             r_last_i;
  logic             r_valid_i;
  logic             r_ready_o;
  data_t            read_rsp_data_o;
  logic             read_rsp_data_valid_o;
  logic             read_rsp_data_ready_i;
  xdma_r_state_e    dbg_state_o;

  xdma_read_data_path #(.data_t(data_t)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .r_desc_i              (r_desc_i),
    .r_dp_valid_i          (r_dp_valid_i),
    .r_dp_ready_o          (r_dp_ready_o),
    .status_o              (status_o),
    .r_data_i              (r_data_i),
    .r_resp_i              (r_resp_i),
    .r_last_i              (r_last_i),
    .r_valid_i             (r_valid_i),
    .r_ready_o             (r_ready_o),
    .read_rsp_data_o       (read_rsp_data_o),
    .read_rsp_data_valid_o (read_rsp_data_valid_o),
    .read_rsp_data_ready_i (read_rsp_data_ready_i),
    .dbg_state_o           (dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];
  int          cyc = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  logic [2:0]  done_status = 3'b000;
  int          last_l_cyc = 0;
  int          discard_viol = 0;
  int          hold_viol = 0;
  int          status_leak = 0;
  bit          cur_fwd = 1'b1;
  bit          strict_lat = 1'b0;
  bit          desc_done = 1'b0;
  bit          prev_stall = 1'b0;
  data_t       prev_data = '0;
  logic [31:0] mon_exp;
  int          mon_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: samples on the falling edge, half a cycle away from the active edge
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (r_valid_i && r_ready_o) begin
        acc_cnt++;
        acc_cyc_q.push_back(cyc);
      end
      if (read_rsp_data_valid_o && read_rsp_data_ready_i) begin
        if (exp_q.size() == 0) begin
          check("local_extra_beat", read_rsp_data_o, 64'hdead_beef_0000_0000);
        end else begin
          mon_exp = exp_q.pop_front();
          check("local_data", read_rsp_data_o, mon_exp);
          mon_t = (acc_cyc_q.size() != 0) ? acc_cyc_q.pop_front() : cyc;
          check("local_latency", strict_lat ? (cyc - mon_t == 1) : (cyc - mon_t >= 1), 1);
        end
        last_l_cyc = cyc;
      end
      if (r_dp_ready_o) begin
        done_cnt++;
        done_status = status_o;
        if (cur_fwd) check("done_after_drain", (exp_q.size() == 0) && (cyc - last_l_cyc >= 2), 1);
      end else if (status_o != 3'b000) begin
        status_leak++;
      end
      if (!cur_fwd && read_rsp_data_valid_o) discard_viol++;
      if (prev_stall && !(read_rsp_data_valid_o && read_rsp_data_o == prev_data)) hold_viol++;
      prev_stall = read_rsp_data_valid_o && !read_rsp_data_ready_i;
      prev_data  = read_rsp_data_o;
    end
  end

  // driver tasks
  task automatic drive_r(input data_t d[$], input logic [1:0] rs[$], input logic lst[$], input int k);
    int idx = 0;
    int guard = 0;
    bit seen = 1'b0;
    while (!seen && guard < 3000) begin
      if (idx < k) begin
        r_valid_i = 1'b1; r_data_i = d[idx]; r_resp_i = rs[idx]; r_last_i = lst[idx];
      end else begin
        // beats past the descriptor's end must be refused
        r_valid_i = 1'b1; r_data_i = $urandom; r_resp_i = 2'b10; r_last_i = 1'b0;
      end
      @(negedge clk_i);
      if (r_valid_i && r_ready_o) idx++;
      if (r_dp_ready_o) seen = 1'b1;
      guard++;
      @(posedge clk_i); #1;
      if (!seen) r_desc_i = xdma_req_r_desc_t'(9'($urandom));
    end
    check("done_within_budget", seen, 1);
    r_valid_i = 1'b0; r_last_i = 1'b0; r_dp_valid_i = 1'b0;
    desc_done = 1'b1;
  endtask

  task automatic drive_rdy(input int mode, input int stall);
    int n = 0;
    while (!desc_done) begin
      case (mode)
        0:       read_rsp_data_ready_i = 1'b1;
        1:       read_rsp_data_ready_i = (n >= stall);
        default: read_rsp_data_ready_i = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk_i);
      if (mode == 1 && n == stall - 1) begin
        check("bp_accepted_beats", acc_cnt, 2);
        check("bp_r_ready_low", r_ready_o, 0);
      end
      n++;
      @(posedge clk_i); #1;
    end
    read_rsp_data_ready_i = 1'b1;
  endtask

  // one descriptor: reference model, stimulus, end-of-descriptor checks
  task automatic run_desc(input string name, input int nb, input bit fwd, input int last_idx,
                          input int err_idx, input int rmode, input int stall, input bit strict);
    data_t      d[$];
    logic [1:0] rs[$];
    logic       lst[$];
    int         k = 0;
    logic [2:0] exp_st = 3'b000;
    for (int i = 0; i <= nb; i++) begin
      d.push_back($urandom);
      rs.push_back((i == err_idx) ? 2'b10 : 2'($urandom_range(0, 1)));
      lst.push_back(i == last_idx);
    end
    // model: beats up to the first RLAST or the counted last beat are consumed
    for (int i = 0; i <= nb; i++) begin
      k = i + 1;
      if (rs[i][1]) exp_st[2] = 1'b1;
      if (lst[i] && i < nb) begin
        exp_st[0] = 1'b1;
        break;
      end
      if (i == nb && !lst[i]) exp_st[1] = 1'b1;
    end
    exp_q.delete();
    acc_cyc_q.delete();
    if (fwd) for (int i = 0; i < k; i++) exp_q.push_back(d[i]);
    acc_cnt = 0; done_cnt = 0; discard_viol = 0; hold_viol = 0; status_leak = 0;
    cur_fwd = fwd; strict_lat = strict; desc_done = 1'b0;
    @(posedge clk_i); #1;
    r_desc_i.num_beats    = 8'(nb);
    r_desc_i.is_read_data = fwd;
    r_dp_valid_i          = 1'b1;
    fork
      drive_r(d, rs, lst, k);
      drive_rdy(rmode, stall);
    join
    repeat (4) @(negedge clk_i);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_status"}, done_status, exp_st);
    check({name, "_r_beats"}, acc_cnt, k);
    check({name, "_undelivered"}, exp_q.size(), 0);
    check({name, "_stream_viol"}, discard_viol + hold_viol + status_leak, 0);
  endtask

  initial begin
    int g;
    int nb, li, ei;
    rst_ni = 1'b0;
    r_desc_i = '0; r_dp_valid_i = 1'b0;
    r_data_i = '0; r_resp_i = 2'b00; r_last_i = 1'b0; r_valid_i = 1'b0;
    read_rsp_data_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_r_ready", r_ready_o, 0);
    check("rst_done", r_dp_ready_o, 0);
    check("rst_status", status_o, 0);
    check("rst_local_valid", read_rsp_data_valid_o, 0);
    check("rst_local_data", read_rsp_data_o, 0);
    check("rst_state", dbg_state_o, IDLE);
    rst_ni = 1'b1;

    run_desc("nominal", 3, 1'b1, 3, -1, 0, 0, 1'b1);
    run_desc("backpressure", 7, 1'b1, 7, -1, 1, 6, 1'b0);
    run_desc("single", 0, 1'b1, 0, -1, 0, 0, 1'b1);
    run_desc("discard", 1, 1'b0, 1, -1, 0, 0, 1'b0);
    run_desc("last_early", 3, 1'b1, 1, -1, 0, 0, 1'b0);
    run_desc("last_missing", 1, 1'b1, -1, -1, 0, 0, 1'b0);
    run_desc("clean_after_err", 2, 1'b1, 2, -1, 0, 0, 1'b1);
    run_desc("resp_err", 2, 1'b1, 2, 1, 0, 0, 1'b0);

    // reset in the middle of a transfer, with two beats parked in the buffer
    exp_q.delete(); cur_fwd = 1'b1; done_cnt = 0; acc_cnt = 0;
    read_rsp_data_ready_i = 1'b0;
    @(posedge clk_i); #1;
    r_desc_i.num_beats = 8'd3; r_desc_i.is_read_data = 1'b1; r_dp_valid_i = 1'b1;
    g = 0;
    while (acc_cnt < 2 && g < 50) begin
      r_valid_i = 1'b1; r_data_i = $urandom; r_resp_i = 2'b00; r_last_i = 1'b0;
      @(negedge clk_i); #1;
      @(posedge clk_i); #1;
      g++;
    end
    r_valid_i = 1'b0; r_dp_valid_i = 1'b0;
    #2;
    check("mid_rst_beats_before", acc_cnt, 2);
    check("mid_rst_valid_before", read_rsp_data_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_local_valid", read_rsp_data_valid_o, 0);
    check("mid_rst_local_data", read_rsp_data_o, 0);
    check("mid_rst_r_ready", r_ready_o, 0);
    check("mid_rst_done", r_dp_ready_o, 0);
    check("mid_rst_status", status_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    read_rsp_data_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("mid_rst_no_done", done_cnt, 0);
    run_desc("post_reset", 3, 1'b1, 3, -1, 0, 0, 1'b0);

    // randomized descriptors with random downstream ready
    for (int t = 0; t < 12; t++) begin
      nb = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0:       li = (nb > 0) ? int'($urandom_range(0, nb - 1)) : nb;
        1:       li = -1;
        default: li = nb;
      endcase
      ei = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb)) : -1;
      run_desc($sformatf("rand%0d", t), nb, 1'($urandom_range(0, 1)), li, ei, 2, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
